// File: rtl/seg_display_driver.sv
// seg_display_driver
// Captures 8-bit values from the Execute stage's {valid, value} bus, converts
// them to decimal digits (shift-add-3) or hex nibbles, and scans them onto four
// common-anode seven-segment digits.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   datainseg  [8] show request, [7:0] value
//   an         active-low one-hot digit enable, an[0] = rightmost digit
//   seg        active-low segments {g,f,e,d,c,b,a}
//   dp         active-low decimal point, held inactive
//   busy       high while a conversion is in flight
module seg_display_driver #(
  parameter logic [15:0] REFRESH_CNT = 16'd50000,
  parameter logic        HEX_MODE    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] datainseg,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int unsigned BIN_W  = 8;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned SH_W   = BCD_W + BIN_W;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ITER_W = 4;
  localparam int unsigned SEG_W  = 7;

  localparam logic [SEG_W-1:0]  BLANK     = 7'h7F;
  localparam logic [ITER_W-1:0] LAST_ITER = 4'd7;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  // Active-low gfedcba pattern for one hex/decimal digit.
  function automatic logic [SEG_W-1:0] encode(input logic [3:0] d);
    logic [SEG_W-1:0] p;
    case (d)
      4'h0: p = 7'b1000000;
      4'h1: p = 7'b1111001;
      4'h2: p = 7'b0100100;
      4'h3: p = 7'b0110000;
      4'h4: p = 7'b0011001;
      4'h5: p = 7'b0010010;
      4'h6: p = 7'b0000010;
      4'h7: p = 7'b1111000;
      4'h8: p = 7'b0000000;
      4'h9: p = 7'b0010000;
      4'hA: p = 7'b0001000;
      4'hB: p = 7'b0000011;
      4'hC: p = 7'b1000110;
      4'hD: p = 7'b0100001;
      4'hE: p = 7'b0000110;
      default: p = 7'b0001110;
    endcase
    return p;
  endfunction

  // Double-dabble correction for one BCD nibble.
  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  state_t                  state, state_n;
  logic [ITER_W-1:0]       iter, iter_n;
  logic [SH_W-1:0]         shreg, shreg_n;
  logic [BIN_W-1:0]        last_value, last_n;
  logic                    have_value, have_n;
  logic [3:0][SEG_W-1:0]   dig, dig_n;
  logic                    busy_n;
  logic [BCD_W-1:0]        bcd_adj;
  logic [3:0]              hund, tens, ones;

  logic [CNT_W-1:0]        cnt;
  logic [1:0]              idx, idx_n;
  logic                    pending;

  // State register and conversion datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      iter       <= '0;
      shreg      <= '0;
      last_value <= '0;
      have_value <= 1'b0;
      dig        <= {4{BLANK}};
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      iter       <= iter_n;
      shreg      <= shreg_n;
      last_value <= last_n;
      have_value <= have_n;
      dig        <= dig_n;
      busy       <= busy_n;
    end
  end

  // Next-state, capture, shift-add-3 and digit load.
  always_comb begin
    state_n = state;
    iter_n  = iter;
    shreg_n = shreg;
    last_n  = last_value;
    have_n  = have_value;
    dig_n   = dig;
    bcd_adj = {adj3(shreg[19:16]), adj3(shreg[15:12]), adj3(shreg[11:8])};
    hund    = shreg[19:16];
    tens    = shreg[15:12];
    ones    = shreg[11:8];

    case (state)
      IDLE: begin
        // Re-requests for the value already shown are dropped.
        if (datainseg[8] && (!have_value || datainseg[7:0] != last_value)) begin
          last_n  = datainseg[7:0];
          shreg_n = {{BCD_W{1'b0}}, datainseg[7:0]};
          have_n  = 1'b1;
          iter_n  = '0;
          state_n = HEX_MODE ? LOAD : SHIFT;
        end
      end
      SHIFT: begin
        shreg_n = SH_W'({bcd_adj, shreg[BIN_W-1:0]} << 1);
        iter_n  = iter + 4'd1;
        if (iter == LAST_ITER) state_n = LOAD;
      end
      LOAD: begin
        state_n = IDLE;
        if (HEX_MODE) begin
          dig_n = {BLANK, BLANK, encode(last_value[7:4]), encode(last_value[3:0])};
        end else begin
          // Leading-zero blanking; ones digit always lit.
          dig_n[3] = BLANK;
          dig_n[2] = (hund != 4'd0) ? encode(hund) : BLANK;
          dig_n[1] = (hund != 4'd0 || tens != 4'd0) ? encode(tens) : BLANK;
          dig_n[0] = encode(ones);
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  assign idx_n = idx + 2'd1;

  // Digit scan; seg also refreshes the cycle after new digits are loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      an      <= 4'b1110;
      seg     <= BLANK;
      pending <= 1'b0;
    end else begin
      pending <= (state == LOAD);
      if (cnt == REFRESH_CNT - 16'd1) begin
        cnt <= '0;
        idx <= idx_n;
        an  <= ~(4'b0001 << idx_n);
        seg <= dig[idx_n];
      end else begin
        cnt <= cnt + 16'd1;
        if (pending) seg <= dig[idx];
      end
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_seg_display_driver.sv
// tb_seg_display_driver
// Drives one decimal-mode and one hex-mode seg_display_driver from a shared
// clock/reset and compares busy, an, seg and dp against a digit-level model.
module tb_seg_display_driver;

  localparam int RC = 4;
  localparam logic [6:0] ENC [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] din_dec, din_hex;
  logic [3:0] an_dec, an_hex;
  logic [6:0] seg_dec, seg_hex;
  logic       dp_dec, dp_hex, busy_dec, busy_hex;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [6:0] m [2][4];
  int         last_v [2];
  bit         have_v [2];

  always #5 clk = ~clk;

  seg_display_driver #(.REFRESH_CNT(16'(RC)), .HEX_MODE(1'b0)) u_dec (
    .clk(clk), .rst_n(rst_n), .datainseg(din_dec),
    .an(an_dec), .seg(seg_dec), .dp(dp_dec), .busy(busy_dec));

  seg_display_driver #(.REFRESH_CNT(16'(RC)), .HEX_MODE(1'b1)) u_hex (
    .clk(clk), .rst_n(rst_n), .datainseg(din_hex),
    .an(an_hex), .seg(seg_hex), .dp(dp_hex), .busy(busy_hex));

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 4; j++) m[d][j] = 7'h7F;
      have_v[d] = 1'b0;
      last_v[d] = 0;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    din_dec = '0;
    din_hex = '0;
    clear_model();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (an_dec !== 4'b1110 || an_hex !== 4'b1110) begin
        errors++;
        $display("FAIL reset_an: got %b/%b expected 1110", an_dec, an_hex);
      end
      checks++;
      if (seg_dec !== 7'h7F || seg_hex !== 7'h7F) begin
        errors++;
        $display("FAIL reset_seg: got %h/%h expected 7f", seg_dec, seg_hex);
      end
      checks++;
      if (busy_dec !== 1'b0 || busy_hex !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy: got %b/%b expected 0", busy_dec, busy_hex);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Sixteen cycles of scanning on both displays against the model.
  task automatic test_scan(input string tag);
    int         idx;
    logic [3:0] e_an;
    for (int i = 0; i < 16; i++) begin
      tick();
      idx  = (cyc / RC) % 4;
      e_an = 4'b0001 << idx;
      e_an = ~e_an;
      checks++;
      if (an_dec !== e_an || an_hex !== e_an) begin
        errors++;
        $display("FAIL %s_an: got %b/%b expected %b", tag, an_dec, an_hex, e_an);
      end
      checks++;
      if (seg_dec !== m[0][idx]) begin
        errors++;
        $display("FAIL %s_seg_dec: digit %0d got %b expected %b", tag, idx, seg_dec, m[0][idx]);
      end
      checks++;
      if (seg_hex !== m[1][idx]) begin
        errors++;
        $display("FAIL %s_seg_hex: digit %0d got %b expected %b", tag, idx, seg_hex, m[1][idx]);
      end
      checks++;
      if (dp_dec !== 1'b1 || dp_hex !== 1'b1) begin
        errors++;
        $display("FAIL %s_dp: got %b/%b expected 1", tag, dp_dec, dp_hex);
      end
    end
  endtask

  // One-cycle request; checks busy profile and exact display latency.
  task automatic test_capture(input bit hx, input int v);
    int         lat, idx, h, t, o;
    bit         cap;
    logic [6:0] newd [4];
    logic [6:0] s;
    logic       b;
    lat = hx ? 2 : 10;
    cap = !have_v[hx] || (v != last_v[hx]);
    for (int j = 0; j < 4; j++) newd[j] = 7'h7F;
    if (hx) begin
      newd[0] = ENC[v % 16];
      newd[1] = ENC[v / 16];
    end else begin
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      newd[2] = (h != 0) ? ENC[h] : 7'h7F;
      newd[1] = (h != 0 || t != 0) ? ENC[t] : 7'h7F;
      newd[0] = ENC[o];
    end
    if (hx) din_hex = {1'b1, 8'(v)};
    else    din_dec = {1'b1, 8'(v)};
    tick();
    din_hex = '0;
    din_dec = '0;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) tick();
      idx = (cyc / RC) % 4;
      s   = hx ? seg_hex : seg_dec;
      b   = hx ? busy_hex : busy_dec;
      checks++;
      if (b !== 1'(cap && k < lat - 1)) begin
        errors++;
        $display("FAIL cap_busy: mode %0d value %0d cycle %0d got %b expected %b",
                 hx, v, k, b, (cap && k < lat - 1));
      end
      if (k == lat && cap) for (int j = 0; j < 4; j++) m[hx][j] = newd[j];
      if (k >= lat - 1) begin
        checks++;
        if (s !== m[hx][idx]) begin
          errors++;
          $display("FAIL cap_seg: mode %0d value %0d cycle %0d digit %0d got %b expected %b",
                   hx, v, k, idx, s, m[hx][idx]);
        end
      end
    end
    if (cap) begin
      last_v[hx] = v;
      have_v[hx] = 1'b1;
    end
  endtask

  // 12 captured, 99 requested mid-conversion and held.
  task automatic test_back_to_back();
    int idx;
    din_dec = 9'h10C;
    tick();
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) tick();
      idx = (cyc / RC) % 4;
      if (k == 3) din_dec = 9'h163;
      if (k == 10) begin
        m[0][2] = 7'h7F; m[0][1] = ENC[1]; m[0][0] = ENC[2];
      end
      if (k == 20) begin
        m[0][2] = 7'h7F; m[0][1] = ENC[9]; m[0][0] = ENC[9];
      end
      checks++;
      if (busy_dec !== 1'(k <= 8 || (k >= 10 && k <= 18))) begin
        errors++;
        $display("FAIL b2b_busy: cycle %0d got %b", k, busy_dec);
      end
      if (k == 9 || k == 10 || k == 19 || k == 20) begin
        checks++;
        if (seg_dec !== m[0][idx]) begin
          errors++;
          $display("FAIL b2b_seg: cycle %0d digit %0d got %b expected %b",
                   k, idx, seg_dec, m[0][idx]);
        end
      end
    end
    din_dec   = '0;
    last_v[0] = 8'h63;
    have_v[0] = 1'b1;
  endtask

  task automatic test_reset_mid_shift();
    din_dec = 9'h12A;
    tick();
    din_dec = '0;
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (busy_dec !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before: got %b expected 1", busy_dec);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_dec !== 1'b0 || busy_hex !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b/%b expected 0", busy_dec, busy_hex);
    end
    checks++;
    if (seg_dec !== 7'h7F || seg_hex !== 7'h7F || an_dec !== 4'b1110) begin
      errors++;
      $display("FAIL abort_display: got seg %h/%h an %b expected 7f/7f 1110",
               seg_dec, seg_hex, an_dec);
    end
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    clear_model();
  endtask

  initial begin
    int v;
    test_reset();
    test_scan("reset");

    test_capture(1'b0, 255);
    test_scan("dec255");
    test_capture(1'b0, 7);
    test_scan("dec7");
    test_capture(1'b0, 0);
    test_capture(1'b0, 0);
    test_scan("dec0");
    for (int i = 0; i < 6; i++) begin
      v = (i == 2) ? last_v[0] : int'($urandom_range(0, 255));
      test_capture(1'b0, v);
    end
    test_scan("dec_rand");

    test_capture(1'b1, 8'hA5);
    test_scan("hexA5");
    for (int i = 0; i < 6; i++) begin
      v = (i == 3) ? last_v[1] : int'($urandom_range(0, 255));
      test_capture(1'b1, v);
    end
    test_scan("hex_rand");

    test_capture(1'b0, 200);
    test_back_to_back();
    test_scan("b2b");

    test_reset_mid_shift();
    test_scan("abort");
    test_capture(1'b0, 0);
    test_capture(1'b1, 0);
    test_scan("post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
